// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its slot queue.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    logic        filled;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot array: slots are reserved at issue, filled by returning data, popped by decode.
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         alloc_en,
  input  logic [31:0]  alloc_pc,
  input  logic         alloc_adel,
  input  logic         fill_en,
  input  logic [31:0]  fill_inst,
  input  logic         pop_en,
  output fetch_entry_t head,
  output logic         full
);

  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     slots_q [DEPTH];
  fetch_entry_t     slots_d [DEPTH];
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0] used_q, used_d;

  always_comb begin
    slots_d     = slots_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    used_d      = used_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) slots_d[i].filled = 1'b0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      used_d      = '0;
    end else begin
      // An address-error slot is born complete; it never waits for bus data.
      if (alloc_en) begin
        slots_d[alloc_ptr_q] = '{pc: alloc_pc, inst: 32'h0, adel: alloc_adel, filled: alloc_adel};
        alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
      end
      if (fill_en) begin
        slots_d[fill_ptr_q].inst   = fill_inst;
        slots_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        slots_d[head_ptr_q].filled = 1'b0;
        head_ptr_d = head_ptr_q + PTR_W'(1);
      end
      used_d = used_q + CNT_W'(alloc_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i].filled <= 1'b0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      used_q      <= '0;
    end else begin
      slots_q     <= slots_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      used_q      <= used_d;
    end
  end

  assign head = slots_q[head_ptr_q];
  // used never exceeds DEPTH, a power of two, so its MSB alone marks full.
  assign full = used_q[PTR_W];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: sequential PC generation, bus issue, in-order response tracking and
// flush-with-discard on redirect, feeding a prefetch slot queue toward decode.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_adel
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = CNT_W + 4;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic              halted_q, halted_d;

  fetch_entry_t head;
  logic         full, misaligned, can_issue, accept, adel_alloc, drop, fill_en, pop;

  assign misaligned = fetch_pc_q[1:0] != 2'b00;
  assign can_issue  = ~rst & ~redirect & ~halted_q & ~full;
  assign inst_req   = can_issue & ~misaligned;
  assign inst_addr  = fetch_pc_q;
  assign accept     = inst_req & inst_addr_ok;
  assign adel_alloc = can_issue & misaligned;
  assign drop       = inst_data_ok & (discard_q != '0);
  assign fill_en    = inst_data_ok & ~rst & ~redirect & (discard_q == '0) & (outstanding_q != '0);
  assign out_valid  = head.filled & ~redirect & ~rst;
  assign pop        = out_valid & out_ready;
  assign out_inst   = rst ? 32'h0 : head.inst;
  assign out_pc     = rst ? 32'h0 : head.pc;
  assign out_adel   = ~rst & head.adel;

  fetch_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect),
    .alloc_en   (accept | adel_alloc),
    .alloc_pc   (fetch_pc_q),
    .alloc_adel (adel_alloc),
    .fill_en    (fill_en),
    .fill_inst  (inst_rdata),
    .pop_en     (pop),
    .head       (head),
    .full       (full)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    halted_d      = halted_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect) begin
      // Everything still in flight becomes garbage; a response landing now is the first of it.
      fetch_pc_d    = redirect_pc;
      halted_d      = 1'b0;
      outstanding_d = '0;
      discard_d     = discard_q + DISC_W'(outstanding_q);
      if (inst_data_ok && discard_d != '0) discard_d = discard_d - DISC_W'(1);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (adel_alloc) halted_d = 1'b1;
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(fill_en);
      if (drop) discard_d = discard_q - DISC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      halted_q      <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      halted_q      <= halted_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule
